// File: rtl/adder_tree_acc_if.sv
// Beat/result bundle between the MAC array and the adder-tree accumulator.
// Latency: none (wires only).
// Backpressure: none; the producer may issue one beat per cycle.
interface adder_tree_acc_if #(
  parameter int BITSIZE    = 14,
  parameter int NUM_INPUTS = 27,
  parameter int ACC_GUARD  = 4
);
  localparam int STAGES = $clog2(NUM_INPUTS);
  localparam int SUM_W  = BITSIZE + STAGES;
  localparam int ACC_W  = SUM_W + ACC_GUARD;

  logic                          start_adder;
  logic [NUM_INPUTS*BITSIZE-1:0] input_numbers;
  logic                          first_pass;
  logic                          last_pass;
  logic signed [SUM_W-1:0]       bias;
  logic signed [ACC_W-1:0]       acc_output;
  logic signed [BITSIZE-1:0]     sat_output;
  logic                          data_valid;
  logic                          overflow;

  // Producer side: drives beats, observes finished groups.
  modport master (
    output start_adder, input_numbers, first_pass, last_pass, bias,
    input  acc_output, sat_output, data_valid, overflow
  );

  // Accumulator side: consumes beats, presents finished groups.
  modport slave (
    input  start_adder, input_numbers, first_pass, last_pass, bias,
    output acc_output, sat_output, data_valid, overflow
  );
endinterface

// File: rtl/adder_tree_acc.sv
// Pipelined signed adder tree with multi-pass saturating accumulation, bias and clamped output.
// Latency: data_valid STAGES+1 cycles after the last_pass beat is sampled.
// Backpressure: none; accepts one beat per cycle, bubbles allowed anywhere.
module adder_tree_acc #(
  parameter int BITSIZE    = 14,
  parameter int NUM_INPUTS = 27,
  parameter int ACC_GUARD  = 4,
  parameter int OUT_SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  adder_tree_acc_if.slave   bus
);
  localparam int STAGES = $clog2(NUM_INPUTS);
  localparam int SUM_W  = BITSIZE + STAGES;
  localparam int ACC_W  = SUM_W + ACC_GUARD;
  localparam int HALF   = (NUM_INPUTS + 1) / 2;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};

  // Number of live elements at tree level l (level 0 = raw operands).
  function automatic int lvl_cnt(input int l);
    return (NUM_INPUTS + (1 << l) - 1) >> l;
  endfunction

  // Every tree element is carried at full SUM_W width; the tree sum is exact.
  logic signed [SUM_W-1:0] lvl    [0:STAGES][0:NUM_INPUTS-1];
  logic signed [SUM_W-1:0] tree_d [0:STAGES-1][0:HALF-1];
  logic signed [SUM_W-1:0] tree_q [0:STAGES-1][0:HALF-1];

  // Sideband shift chain, aligned with the tree levels.
  logic [STAGES-1:0]       sb_vld_d,   sb_vld_q;
  logic [STAGES-1:0]       sb_first_d, sb_first_q;
  logic [STAGES-1:0]       sb_last_d,  sb_last_q;
  logic signed [SUM_W-1:0] sb_bias_d [0:STAGES-1];
  logic signed [SUM_W-1:0] sb_bias_q [0:STAGES-1];

  // Accumulator stage.
  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic                    ovf_d, ovf_q;
  logic                    open_d, open_q;
  logic                    done_d, done_q;
  logic signed [ACC_W-1:0] base, sum_ext;
  logic signed [ACC_W:0]   wide;
  logic                    sticky;

  // Output stage.
  logic signed [ACC_W-1:0]   shifted;
  logic signed [BITSIZE-1:0] sat_val;
  logic                      out_vld_d, out_vld_q;
  logic signed [ACC_W-1:0]   out_acc_d, out_acc_q;
  logic signed [BITSIZE-1:0] out_sat_d, out_sat_q;
  logic                      out_ovf_d, out_ovf_q;

  // Level view: sign-extended operands at level 0, registered partial sums above.
  always_comb begin
    for (int j = 0; j < NUM_INPUTS; j++) begin
      lvl[0][j] = SUM_W'($signed(bus.input_numbers[j*BITSIZE +: BITSIZE]));
    end
    for (int l = 1; l <= STAGES; l++) begin
      for (int j = 0; j < NUM_INPUTS; j++) begin
        lvl[l][j] = (j < HALF) ? tree_q[l-1][j] : '0;
      end
    end
  end

  // Pairwise add per level; an odd trailing element passes through unchanged.
  always_comb begin
    int ia;
    int ib;
    for (int l = 0; l < STAGES; l++) begin
      for (int j = 0; j < HALF; j++) begin
        tree_d[l][j] = '0;
      end
    end
    for (int l = 1; l <= STAGES; l++) begin
      for (int j = 0; j < HALF; j++) begin
        ia = 2 * j;
        ib = (2 * j + 1 < NUM_INPUTS) ? 2 * j + 1 : 2 * j;
        if (j < lvl_cnt(l)) begin
          if (2 * j + 1 < lvl_cnt(l - 1)) begin
            tree_d[l-1][j] = lvl[l-1][ia] + lvl[l-1][ib];
          end else begin
            tree_d[l-1][j] = lvl[l-1][ia];
          end
        end
      end
    end
  end

  // Tree level registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l < STAGES; l++) begin
        for (int j = 0; j < HALF; j++) begin
          tree_q[l][j] <= '0;
        end
      end
    end else begin
      tree_q <= tree_d;
    end
  end

  // Sideband advance; flags only count on valid beats.
  always_comb begin
    sb_vld_d[0]   = bus.start_adder;
    sb_first_d[0] = bus.start_adder & bus.first_pass;
    sb_last_d[0]  = bus.start_adder & bus.last_pass;
    sb_bias_d[0]  = bus.bias;
    for (int i = 1; i < STAGES; i++) begin
      sb_vld_d[i]   = sb_vld_q[i-1];
      sb_first_d[i] = sb_first_q[i-1];
      sb_last_d[i]  = sb_last_q[i-1];
      sb_bias_d[i]  = sb_bias_q[i-1];
    end
  end

  // Sideband registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_vld_q   <= '0;
      sb_first_q <= '0;
      sb_last_q  <= '0;
      for (int i = 0; i < STAGES; i++) begin
        sb_bias_q[i] <= '0;
      end
    end else begin
      sb_vld_q   <= sb_vld_d;
      sb_first_q <= sb_first_d;
      sb_last_q  <= sb_last_d;
      sb_bias_q  <= sb_bias_d;
    end
  end

  // Saturating accumulate; a beat with no open group and no first flag starts from zero.
  always_comb begin
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    open_d  = open_q;
    done_d  = 1'b0;
    base    = '0;
    sticky  = 1'b0;
    wide    = '0;
    sum_ext = ACC_W'(tree_q[STAGES-1][0]);
    if (sb_vld_q[STAGES-1]) begin
      if (sb_first_q[STAGES-1]) begin
        base = ACC_W'(sb_bias_q[STAGES-1]);
      end else if (open_q) begin
        base   = acc_q;
        sticky = ovf_q;
      end
      wide = (ACC_W+1)'(base) + (ACC_W+1)'(sum_ext);
      if (wide[ACC_W] != wide[ACC_W-1]) begin
        acc_d = wide[ACC_W] ? ACC_MIN : ACC_MAX;
        ovf_d = 1'b1;
      end else begin
        acc_d = wide[ACC_W-1:0];
        ovf_d = sticky;
      end
      open_d = ~sb_last_q[STAGES-1];
      done_d = sb_last_q[STAGES-1];
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      open_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      open_q <= open_d;
      done_q <= done_d;
    end
  end

  // Floor shift then clamp to the operand range; results held between groups.
  always_comb begin
    shifted = acc_q >>> OUT_SHIFT;
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[BITSIZE-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[BITSIZE-1:0];
    end else begin
      sat_val = shifted[BITSIZE-1:0];
    end
    out_vld_d = done_q;
    out_acc_d = done_q ? acc_q   : out_acc_q;
    out_sat_d = done_q ? sat_val : out_sat_q;
    out_ovf_d = done_q ? ovf_q   : out_ovf_q;
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld_q <= 1'b0;
      out_acc_q <= '0;
      out_sat_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      out_vld_q <= out_vld_d;
      out_acc_q <= out_acc_d;
      out_sat_q <= out_sat_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign bus.data_valid = out_vld_q;
  assign bus.acc_output = out_acc_q;
  assign bus.sat_output = out_sat_q;
  assign bus.overflow   = out_ovf_q;
endmodule

// File: tb/tb_adder_tree_acc.sv
// Randomised and directed scoreboard bench for adder_tree_acc (OUT_SHIFT 0 and 3 side by side).
// Latency: expects each finished group STAGES+1 cycles after its last beat.
// Backpressure: none; the bench issues beats freely.
module tb_adder_tree_acc;
  localparam int BITSIZE    = 14;
  localparam int NUM_INPUTS = 27;
  localparam int ACC_GUARD  = 4;
  localparam int STAGES     = $clog2(NUM_INPUTS);
  localparam int SUM_W      = BITSIZE + STAGES;
  localparam int ACC_W      = SUM_W + ACC_GUARD;
  localparam int LAT        = STAGES + 1;
  localparam longint ACC_HI = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint ACC_LO = -(longint'(1) <<< (ACC_W - 1));
  localparam longint SAT_HI = (longint'(1) <<< (BITSIZE - 1)) - 1;
  localparam longint SAT_LO = -(longint'(1) <<< (BITSIZE - 1));

  typedef struct {
    longint acc;
    longint sat0;
    longint sat3;
    longint ovf;
    int     cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_adder = 1'b0;
  logic first_pass = 1'b0;
  logic last_pass = 1'b0;
  logic [NUM_INPUTS*BITSIZE-1:0] input_numbers = '0;
  logic signed [SUM_W-1:0] bias = '0;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  exp_t q[$];

  int     ops [NUM_INPUTS];
  bit     m_open = 1'b0;
  longint m_acc = 0;
  bit     m_ovf = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_tree_acc_if #(.BITSIZE(BITSIZE), .NUM_INPUTS(NUM_INPUTS), .ACC_GUARD(ACC_GUARD)) if0 ();
  adder_tree_acc_if #(.BITSIZE(BITSIZE), .NUM_INPUTS(NUM_INPUTS), .ACC_GUARD(ACC_GUARD)) if1 ();

  assign if0.start_adder   = start_adder;
  assign if0.input_numbers = input_numbers;
  assign if0.first_pass    = first_pass;
  assign if0.last_pass     = last_pass;
  assign if0.bias          = bias;
  assign if1.start_adder   = start_adder;
  assign if1.input_numbers = input_numbers;
  assign if1.first_pass    = first_pass;
  assign if1.last_pass     = last_pass;
  assign if1.bias          = bias;

  adder_tree_acc #(.BITSIZE(BITSIZE), .NUM_INPUTS(NUM_INPUTS), .ACC_GUARD(ACC_GUARD), .OUT_SHIFT(0))
    u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  adder_tree_acc #(.BITSIZE(BITSIZE), .NUM_INPUTS(NUM_INPUTS), .ACC_GUARD(ACC_GUARD), .OUT_SHIFT(3))
    u_dut3 (.clk(clk), .rst(rst), .bus(if1));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint sat_of(input longint a, input int sh);
    longint s;
    s = a >>> sh;
    if (s > SAT_HI) return SAT_HI;
    if (s < SAT_LO) return SAT_LO;
    return s;
  endfunction

  task automatic fill(input int v);
    for (int j = 0; j < NUM_INPUTS; j++) ops[j] = v;
  endtask

  task automatic fill_rand();
    for (int j = 0; j < NUM_INPUTS; j++) ops[j] = int'($urandom_range(16383)) - 8192;
  endtask

  // Drive one beat and advance the reference model by the group rules.
  task automatic issue(input bit f, input bit l, input longint b);
    longint s;
    longint base;
    bit     ovb;
    exp_t   e;
    s = 0;
    @(negedge clk);
    for (int j = 0; j < NUM_INPUTS; j++) begin
      input_numbers[j*BITSIZE +: BITSIZE] = ops[j][BITSIZE-1:0];
      s += ops[j];
    end
    start_adder = 1'b1;
    first_pass  = f;
    last_pass   = l;
    bias        = SUM_W'(b);
    if (f) begin
      base = b; ovb = 1'b0;
    end else if (m_open) begin
      base = m_acc; ovb = m_ovf;
    end else begin
      base = 0; ovb = 1'b0;
    end
    m_acc = base + s;
    m_ovf = ovb;
    if (m_acc > ACC_HI) begin m_acc = ACC_HI; m_ovf = 1'b1; end
    if (m_acc < ACC_LO) begin m_acc = ACC_LO; m_ovf = 1'b1; end
    m_open = !l;
    if (l) begin
      e.acc  = m_acc;
      e.sat0 = sat_of(m_acc, 0);
      e.sat3 = sat_of(m_acc, 3);
      e.ovf  = longint'(m_ovf);
      e.cyc  = cyc + 1;
      q.push_back(e);
    end
  endtask

  // Idle cycles; flags toggle randomly to show they are ignored without a beat.
  task automatic bubble(input int n);
    repeat (n) begin
      @(negedge clk);
      start_adder = 1'b0;
      first_pass  = 1'($urandom_range(1));
      last_pass   = 1'($urandom_range(1));
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_acc0"}, if0.acc_output, 0);
    chk({tag, "_sat0"}, if0.sat_output, 0);
    chk({tag, "_vld0"}, if0.data_valid, 0);
    chk({tag, "_ovf0"}, if0.overflow, 0);
    chk({tag, "_acc3"}, if1.acc_output, 0);
    chk({tag, "_vld3"}, if1.data_valid, 0);
  endtask

  // Monitor: every data_valid pops one expected group and compares both instances.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && if0.data_valid) begin
        chk("expect_pending", longint'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("acc_output", if0.acc_output, e.acc);
          chk("sat_output", if0.sat_output, e.sat0);
          chk("overflow", if0.overflow, e.ovf);
          chk("latency", longint'(cyc - e.cyc), LAT);
          chk("shift3_valid", if1.data_valid, 1);
          chk("shift3_acc", if1.acc_output, e.acc);
          chk("shift3_sat", if1.sat_output, e.sat3);
        end
      end else if (rst && if1.data_valid) begin
        chk("shift3_lone_valid", if1.data_valid, if0.data_valid);
      end
    end
  end

  initial begin
    fill(0);
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b1;
    bubble(2);

    // Single pass, negative sum clamps at the output.
    fill(-416);
    issue(1, 1, 0);
    bubble(LAT + 2);

    // Three passes with bias, back to back and then with bubbles.
    fill(1); issue(1, 0, 5);
    fill(2); issue(0, 0, 0);
    fill(3); issue(0, 1, 0);
    bubble(LAT + 2);
    fill(1); issue(1, 0, 5); bubble(2);
    fill(2); issue(0, 0, 0); bubble(1);
    fill(3); issue(0, 1, 0);
    bubble(LAT + 2);

    // Streaming single-pass groups.
    for (int k = 1; k <= 10; k++) begin
      fill(k);
      issue(1, 1, 0);
    end
    bubble(LAT + 2);

    // Accumulator overflow, then a clean group.
    fill(8191);
    for (int i = 0; i < 32; i++) issue(i == 0, i == 31, 0);
    fill(1);
    issue(1, 1, 0);
    bubble(LAT + 2);

    // Reset in the middle of a group.
    fill(100);
    issue(1, 0, 7);
    bubble(1);
    @(negedge clk);
    rst = 1'b0;
    m_open = 1'b0; m_acc = 0; m_ovf = 1'b0;
    @(negedge clk);
    check_cleared("midreset");
    @(negedge clk);
    rst = 1'b1;
    bubble(LAT + 2);
    fill(3);
    issue(0, 1, 0);
    fill(4); issue(1, 0, -20);
    fill(-4); issue(0, 1, 0);
    bubble(LAT + 2);

    // Restart: an open group is abandoned by a new first beat.
    fill(5); issue(1, 0, 11);
    fill(7); issue(0, 0, 0);
    fill(2); issue(1, 0, -9);
    fill(2); issue(0, 1, 0);
    bubble(LAT + 2);

    // Random beats, flags and bubbles.
    for (int n = 0; n < 150; n++) begin
      fill_rand();
      issue(($urandom_range(3) == 0), ($urandom_range(2) == 0),
            longint'(int'($urandom_range(131071)) - 65536));
      if ($urandom_range(3) == 0) bubble(int'($urandom_range(1, 3)));
    end
    bubble(LAT + 4);

    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
